gpr_file: RTL and testbench
===========================

# gpr_file

Parametrised general-purpose register file for the SAP-2 datapath. It replaces the fixed A/B/C `register` instances and the per-register `flags` loads. It offers N indexed registers with load, increment/decrement, move, clear, test and a two-cycle swap, plus one bus read port. The read port feeds the shared bus mux, and the flags output feeds `controller` the same way `flags_out` does today.

## Interface
Parameters:
- `WIDTH`, 8: register and bus data width (≥2).
- `NREGS`, 4: number of registers (≥2).
- `AW`, `$clog2(NREGS)`: index width. Derived; never overridden.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `op`, in, 3: operation, encodings in `gpr_pkg`.
- `dst`, in, AW: destination index.
- `src`, in, AW: source index for MOV/SWAP/TEST.
- `bus`, in, WIDTH: LOAD data.
- `en`, in, 1: drive read port.
- `rsel`, in, AW: read-port index.
- `out`, out, WIDTH: value of R[rsel] when `en`, else 0.
- `flags_out`, out, 3: {carry, sign, zero}.
- `busy`, out, 1: high during the second swap cycle.

## Operation
- Opcodes:
  - 0 NOP.
  - 1 LOAD: R[dst]←bus.
  - 2 INC: R[dst]←R[dst]+1.
  - 3 DEC: R[dst]←R[dst]−1.
  - 4 MOV: R[dst]←R[src].
  - 5 SWAP: exchange R[dst] and R[src].
  - 6 CLR: R[dst]←0.
  - 7 TEST: flags from R[src], no write.
- Arithmetic is modulo 2^WIDTH.
- Carry is set when INC wraps all-ones→0, or when DEC borrows 0→all-ones.
- LOAD, CLR and TEST clear carry.
- Flags are updated by LOAD, INC, DEC, CLR (from the written value) and TEST (from R[src]): zero = value==0, sign = value[WIDTH−1].
- MOV, SWAP and NOP leave flags unchanged.
- SWAP FSM, states IDLE and SWAP2:
  - IDLE with op=SWAP: tmp←R[src], R[src]←R[dst], go to SWAP2.
  - SWAP2: R[dst]←tmp (the `dst` latched at issue), `busy`=1, return to IDLE.
- While `busy`=1, `op` is ignored entirely: no write, no flag change.
- An index ≥NREGS on a write or flag op makes the op a NOP. An index ≥NREGS on `rsel` reads 0.
- An out-of-range index on a SWAP makes it a NOP: no transition to SWAP2.
- MOV or SWAP with src==dst leaves the register unchanged. SWAP still takes two cycles.

## Timing
- Reset: all R=0, tmp=0, state IDLE, `flags_out`=3'b000, `busy`=0, `out`=0.
- Reset wins over any op, including mid-SWAP. The pending second write is discarded.
- All writes and flag updates take effect at the rising edge where `op` is sampled. New values are visible the cycle after.
- `out` is combinational from `en`, `rsel` and current register state. On the edge where R[rsel] is written, `out` shows the pre-edge value.
- Simultaneous read and write of the same register has no bypass.
- SWAP latency is 2 cycles. Both registers hold swapped values from the cycle after SWAP2. During SWAP2, R[src] is already new and R[dst] is still old.

## Structure
- `gpr_pkg` holds:
  - op encodings: `GPR_NOP` … `GPR_TEST`;
  - flag bit positions: `FLG_Z`=0, `FLG_S`=1, `FLG_C`=2;
  - FSM state typedef: IDLE and SWAP2.
- One sub-module, `gpr_incdec`: combinational WIDTH-bit ±1 with carry/borrow out, shared by INC and DEC.
- The register array, FSM and flag logic live in `gpr_file`.

## Test plan
All scenarios use WIDTH=8, NREGS=4.
- Reset then read: `rst`=1 for one edge, `en`=1, `rsel`=0..3 → `out`=0x00 for every index; `flags_out`=000; `busy`=0.
- LOAD/INC wrap: LOAD R1←0xFF, then INC R1 → R1=0x00, flags C=1 S=0 Z=1; next DEC R1 → 0xFF, C=1 S=1 Z=0.
- MOV/TEST: LOAD R2←0x80, MOV R3←R2, TEST src=3 → `out`(rsel=3)=0x80; flags C=0 S=1 Z=0; MOV alone does not alter flags.
- SWAP with busy:
  - Setup: R0=0x11, R1=0x22.
  - Issue SWAP dst=0 src=1 with INC R0 on the following cycle.
  - Expect `busy`=1 for exactly one cycle and the INC ignored.
  - Then R0=0x22, R1=0x11.
- Reset mid-SWAP: assert `rst` during SWAP2 → all registers 0x00, `busy`=0 the next cycle, no residual write.
- Out-of-range/same-index (NREGS=3 build): LOAD dst=3 with 0x55 → no register changes, flags unchanged, `out`(rsel=3)=0. SWAP src=dst=1 → R1 unchanged after 2 cycles.

Source files
------------

// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - shared encodings for the general-purpose register file
package gpr_pkg;

    localparam logic [2:0] GPR_NOP  = 3'd0;
    localparam logic [2:0] GPR_LOAD = 3'd1;
    localparam logic [2:0] GPR_INC  = 3'd2;
    localparam logic [2:0] GPR_DEC  = 3'd3;
    localparam logic [2:0] GPR_MOV  = 3'd4;
    localparam logic [2:0] GPR_SWAP = 3'd5;
    localparam logic [2:0] GPR_CLR  = 3'd6;
    localparam logic [2:0] GPR_TEST = 3'd7;

    localparam int FLG_Z = 0;
    localparam int FLG_S = 1;
    localparam int FLG_C = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SWAP2 = 1'b1
    } gpr_state_t;

    function automatic logic [2:0] make_flags(input logic carry, input logic sign, input logic zero);
        logic [2:0] f;
        f        = 3'b000;
        f[FLG_C] = carry;
        f[FLG_S] = sign;
        f[FLG_Z] = zero;
        return f;
    endfunction

endpackage

// File: rtl/gpr_incdec.sv
// rtl/gpr_incdec.sv - combinational +/-1 with carry/borrow out
module gpr_incdec #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic             dec,
    output logic [WIDTH-1:0] y,
    output logic             cout
);

    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0] ext;

    // The extra top bit is the wrap indicator for both directions.
    assign ext     = dec ? ({1'b0, a} - ONE) : ({1'b0, a} + ONE);
    assign y       = ext[WIDTH-1:0];
    assign cout    = ext[WIDTH];

endmodule

// File: rtl/gpr_file.sv
// rtl/gpr_file.sv - indexed register file with load/inc/dec/mov/swap/clr/test and one read port
module gpr_file
    import gpr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    dst,
    input  logic [AW-1:0]    src,
    input  logic [WIDTH-1:0] bus,
    input  logic             en,
    input  logic [AW-1:0]    rsel,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       flags_out,
    output logic             busy
);

    localparam logic [AW:0] NREGS_L = (AW+1)'(NREGS);

    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] tmp;
    logic [AW-1:0]    dst_q;
    gpr_state_t       state;

    logic             dst_ok, src_ok, rsel_ok;
    logic [WIDTH-1:0] dst_val, src_val;
    logic [WIDTH-1:0] id_y;
    logic             id_c;

    assign dst_ok  = {1'b0, dst}  < NREGS_L;
    assign src_ok  = {1'b0, src}  < NREGS_L;
    assign rsel_ok = {1'b0, rsel} < NREGS_L;

    assign dst_val = dst_ok ? regs[dst] : '0;
    assign src_val = src_ok ? regs[src] : '0;

    gpr_incdec #(.WIDTH(WIDTH)) u_incdec (
        .a    (dst_val),
        .dec  (op == GPR_DEC),
        .y    (id_y),
        .cout (id_c)
    );

    assign out  = (en && rsel_ok) ? regs[rsel] : '0;
    assign busy = (state == SWAP2);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            tmp       <= '0;
            dst_q     <= '0;
            state     <= IDLE;
            flags_out <= 3'b000;
        end else if (state == SWAP2) begin
            // Second half of the swap; op is ignored this cycle.
            regs[dst_q] <= tmp;
            state       <= IDLE;
        end else begin
            case (op)
                GPR_LOAD: if (dst_ok) begin
                    regs[dst] <= bus;
                    flags_out <= make_flags(1'b0, bus[WIDTH-1], bus == '0);
                end
                GPR_INC, GPR_DEC: if (dst_ok) begin
                    regs[dst] <= id_y;
                    flags_out <= make_flags(id_c, id_y[WIDTH-1], id_y == '0);
                end
                GPR_MOV: if (dst_ok && src_ok) begin
                    regs[dst] <= src_val;
                end
                GPR_SWAP: if (dst_ok && src_ok) begin
                    tmp       <= src_val;
                    regs[src] <= dst_val;
                    dst_q     <= dst;
                    state     <= SWAP2;
                end
                GPR_CLR: if (dst_ok) begin
                    regs[dst] <= '0;
                    flags_out <= make_flags(1'b0, 1'b0, 1'b1);
                end
                GPR_TEST: if (src_ok) begin
                    flags_out <= make_flags(1'b0, src_val[WIDTH-1], src_val == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gpr_file.sv
// tb/tb_gpr_file.sv - directed bench for gpr_file (4-register and 3-register builds)
module tb_gpr_file;
    import gpr_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [2:0] op = GPR_NOP;
    logic [1:0] dst = '0, src = '0, rsel = '0;
    logic [7:0] bus = '0;
    logic       en = 1'b1;
    logic [7:0] out;
    logic [2:0] flags_out;
    logic       busy;

    logic [2:0] op3 = GPR_NOP;
    logic [1:0] dst3 = '0, src3 = '0, rsel3 = '0;
    logic [7:0] bus3 = '0;
    logic       en3 = 1'b1;
    logic [7:0] out3;
    logic [2:0] flags3;
    logic       busy3;

    int n_cmp = 0;
    int n_bad = 0;

    always #10 clk = ~clk;

    gpr_file #(.WIDTH(8), .NREGS(4)) u_dut (
        .clk(clk), .rst(rst), .op(op), .dst(dst), .src(src), .bus(bus),
        .en(en), .rsel(rsel), .out(out), .flags_out(flags_out), .busy(busy)
    );

    gpr_file #(.WIDTH(8), .NREGS(3)) u_dut3 (
        .clk(clk), .rst(rst), .op(op3), .dst(dst3), .src(src3), .bus(bus3),
        .en(en3), .rsel(rsel3), .out(out3), .flags_out(flags3), .busy(busy3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [1:0] d, input logic [1:0] s, input logic [7:0] b);
        op = o; dst = d; src = s; bus = b;
        tick();
        op = GPR_NOP;
    endtask

    task automatic issue3(input logic [2:0] o, input logic [1:0] d, input logic [1:0] s, input logic [7:0] b);
        op3 = o; dst3 = d; src3 = s; bus3 = b;
        tick();
        op3 = GPR_NOP;
    endtask

    task automatic rd(input logic [1:0] sel, output logic [7:0] v);
        en = 1'b1; rsel = sel;
        #1;
        v = out;
    endtask

    task automatic rd3(input logic [1:0] sel, output logic [7:0] v);
        en3 = 1'b1; rsel3 = sel;
        #1;
        v = out3;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1;
        op = GPR_LOAD; dst = 2'd0; bus = 8'hEE;
        tick();
        rst = 1'b0; op = GPR_NOP;
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), v);
            n_cmp++;
            if (v !== 8'h00) begin n_bad++; $display("FAIL reset_out[%0d] got %h want 00", i, v); end
        end
        n_cmp++;
        if (flags_out !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", flags_out); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++;
        if (flags3 !== 3'b000 || busy3 !== 1'b0) begin n_bad++; $display("FAIL reset3 got flags %b busy %b want 000 0", flags3, busy3); end
    endtask

    task automatic test_load_inc_wrap();
        logic [7:0] v;
        issue(GPR_LOAD, 2'd1, 2'd0, 8'hFF);
        rd(2'd1, v);
        n_cmp++;
        if (v !== 8'hFF || flags_out !== 3'b010) begin n_bad++; $display("FAIL load_ff got %h/%b want ff/010", v, flags_out); end
        issue(GPR_INC, 2'd1, 2'd0, 8'h00);
        rd(2'd1, v);
        n_cmp++;
        if (v !== 8'h00 || flags_out !== 3'b101) begin n_bad++; $display("FAIL inc_wrap got %h/%b want 00/101", v, flags_out); end
        issue(GPR_DEC, 2'd1, 2'd0, 8'h00);
        rd(2'd1, v);
        n_cmp++;
        if (v !== 8'hFF || flags_out !== 3'b110) begin n_bad++; $display("FAIL dec_borrow got %h/%b want ff/110", v, flags_out); end
        issue(GPR_DEC, 2'd1, 2'd0, 8'h00);
        rd(2'd1, v);
        n_cmp++;
        if (v !== 8'hFE || flags_out !== 3'b010) begin n_bad++; $display("FAIL dec_plain got %h/%b want fe/010", v, flags_out); end
    endtask

    task automatic test_mov_test();
        logic [7:0] v;
        issue(GPR_LOAD, 2'd2, 2'd0, 8'h80);
        issue(GPR_CLR, 2'd0, 2'd0, 8'h00);
        n_cmp++;
        if (flags_out !== 3'b001) begin n_bad++; $display("FAIL clr_flags got %b want 001", flags_out); end
        issue(GPR_MOV, 2'd3, 2'd2, 8'h00);
        rd(2'd3, v);
        n_cmp++;
        if (v !== 8'h80) begin n_bad++; $display("FAIL mov_val got %h want 80", v); end
        n_cmp++;
        if (flags_out !== 3'b001) begin n_bad++; $display("FAIL mov_flags got %b want 001", flags_out); end
        issue(GPR_TEST, 2'd0, 2'd3, 8'h00);
        n_cmp++;
        if (flags_out !== 3'b010) begin n_bad++; $display("FAIL test_flags got %b want 010", flags_out); end
        en = 1'b0; rsel = 2'd3;
        #1;
        n_cmp++;
        if (out !== 8'h00) begin n_bad++; $display("FAIL en_low_out got %h want 00", out); end
        en = 1'b1;
    endtask

    task automatic test_swap_busy();
        logic [7:0] v0, v1;
        issue(GPR_LOAD, 2'd0, 2'd0, 8'h11);
        issue(GPR_LOAD, 2'd1, 2'd0, 8'h22);
        op = GPR_SWAP; dst = 2'd0; src = 2'd1;
        tick();
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL swap_busy1 got %b want 1", busy); end
        rd(2'd0, v0); rd(2'd1, v1);
        n_cmp++;
        if (v0 !== 8'h11 || v1 !== 8'h11) begin n_bad++; $display("FAIL swap_mid got r0=%h r1=%h want 11 11", v0, v1); end
        op = GPR_INC; dst = 2'd0;
        tick();
        op = GPR_NOP;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL swap_busy2 got %b want 0", busy); end
        rd(2'd0, v0); rd(2'd1, v1);
        n_cmp++;
        if (v0 !== 8'h22 || v1 !== 8'h11) begin n_bad++; $display("FAIL swap_done got r0=%h r1=%h want 22 11", v0, v1); end
        n_cmp++;
        if (flags_out !== 3'b000) begin n_bad++; $display("FAIL swap_flags got %b want 000", flags_out); end
        tick();
        rd(2'd0, v0);
        n_cmp++;
        if (v0 !== 8'h22 || busy !== 1'b0) begin n_bad++; $display("FAIL swap_after got r0=%h busy=%b want 22 0", v0, busy); end
    endtask

    task automatic test_reset_mid_swap();
        logic [7:0] v;
        issue(GPR_LOAD, 2'd2, 2'd0, 8'h33);
        op = GPR_SWAP; dst = 2'd2; src = 2'd3;
        tick();
        op = GPR_NOP;
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL midswap_busy got %b want 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || flags_out !== 3'b000) begin n_bad++; $display("FAIL midswap_rst got busy=%b flags=%b want 0 000", busy, flags_out); end
        tick();
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), v);
            n_cmp++;
            if (v !== 8'h00) begin n_bad++; $display("FAIL midswap_reg[%0d] got %h want 00", i, v); end
        end
    endtask

    task automatic test_range_same_index();
        logic [7:0] v0, v1, v2;
        issue3(GPR_LOAD, 2'd1, 2'd0, 8'h5A);
        issue3(GPR_LOAD, 2'd0, 2'd0, 8'hAA);
        issue3(GPR_LOAD, 2'd3, 2'd0, 8'h55);
        rd3(2'd0, v0); rd3(2'd1, v1); rd3(2'd2, v2);
        n_cmp++;
        if (v0 !== 8'hAA || v1 !== 8'h5A || v2 !== 8'h00) begin n_bad++; $display("FAIL oor_load got %h %h %h want aa 5a 00", v0, v1, v2); end
        n_cmp++;
        if (flags3 !== 3'b010) begin n_bad++; $display("FAIL oor_flags got %b want 010", flags3); end
        rd3(2'd3, v0);
        n_cmp++;
        if (v0 !== 8'h00) begin n_bad++; $display("FAIL oor_read got %h want 00", v0); end
        op3 = GPR_SWAP; dst3 = 2'd0; src3 = 2'd3;
        tick();
        op3 = GPR_NOP;
        rd3(2'd0, v0);
        n_cmp++;
        if (busy3 !== 1'b0 || v0 !== 8'hAA) begin n_bad++; $display("FAIL oor_swap got busy=%b r0=%h want 0 aa", busy3, v0); end
        op3 = GPR_SWAP; dst3 = 2'd1; src3 = 2'd1;
        tick();
        op3 = GPR_NOP;
        n_cmp++;
        if (busy3 !== 1'b1) begin n_bad++; $display("FAIL same_swap_busy got %b want 1", busy3); end
        tick();
        rd3(2'd1, v1);
        n_cmp++;
        if (busy3 !== 1'b0 || v1 !== 8'h5A) begin n_bad++; $display("FAIL same_swap got busy=%b r1=%h want 0 5a", busy3, v1); end
    endtask

    initial begin
        tick();
        test_reset();
        test_load_inc_wrap();
        test_mov_test();
        test_swap_busy();
        test_reset_mid_swap();
        test_range_same_index();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
